// File: rtl/maple_phy_ctrl_if.sv
// rtl/maple_phy_ctrl_if.sv - Transmitter/receiver core side of the Maple pin controller
interface maple_core_if;
    logic tx_sdcka;
    logic tx_sdckb;
    logic tx_active;
    logic tx_grant;
    logic rx_sdcka;
    logic rx_sdckb;
    logic rx_active;

    modport master (
        output tx_sdcka, tx_sdckb, tx_active, rx_active,
        input  tx_grant, rx_sdcka, rx_sdckb
    );

    modport slave (
        input  tx_sdcka, tx_sdckb, tx_active, rx_active,
        output tx_grant, rx_sdcka, rx_sdckb
    );
endinterface

// File: rtl/maple_phy_ctrl.sv
// rtl/maple_phy_ctrl.sv - Multi-port Maple Bus pin controller: direction FSM, port mux, input conditioning
module maple_phy_ctrl #(
    parameter int NUM_PORTS   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int TURN_CYCLES = 8,
    parameter int TIMEOUT_W   = 20,
    localparam int PSEL_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [PSEL_W-1:0]    cfg_port_sel,
    input  logic                 cfg_enable_tx,
    input  logic                 cfg_enable_rx,
    input  logic                 cfg_loopback,
    input  logic [TIMEOUT_W-1:0] cfg_rx_timeout,
    maple_core_if.slave          core,
    input  logic [NUM_PORTS-1:0] pad_sdcka_i,
    input  logic [NUM_PORTS-1:0] pad_sdckb_i,
    output logic [NUM_PORTS-1:0] pad_sdcka_o,
    output logic [NUM_PORTS-1:0] pad_sdckb_o,
    output logic [NUM_PORTS-1:0] pad_oe,
    output logic [1:0]           state,
    output logic                 rx_done,
    output logic                 rx_timeout,
    output logic                 tx_collision
);
    localparam int NL  = 2 * NUM_PORTS;
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TCW = $clog2(TURN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_TURN   = 2'd2,
        ST_LISTEN = 2'd3
    } state_e;

    state_e                         state_q, state_d;
    logic [PSEL_W-1:0]              port_q, port_d;
    logic [TCW-1:0]                 turn_q, turn_d;
    logic [TIMEOUT_W-1:0]           timer_q, timer_d;
    logic                           seen_q, seen_d;
    logic                           tx_prev_q, rx_prev_q;
    logic [SYNC_STAGES-1:0][NL-1:0] sync_q, sync_d;
    logic [NL-1:0]                  filt_q, filt_d;
    logic [NL-1:0][FCW-1:0]         fcnt_q, fcnt_d;
    logic [NUM_PORTS-1:0]           oe_q, oe_d;
    logic [NUM_PORTS-1:0]           pad_a_q, pad_a_d, pad_b_q, pad_b_d;
    logic                           rx_a_q, rx_a_d, rx_b_q, rx_b_d;
    logic                           grant_q, grant_d;
    logic                           done_q, done_d, tmo_q, tmo_d, coll_q, coll_d;
    logic [NL-1:0]                  synced;
    logic [NUM_PORTS-1:0]           filt_a_d, filt_b_d;
    logic                           tx_rise, tx_fall, rx_fall, sel_ok;

    // Pad lines are handled as one vector: a-lines in the low half, b-lines in the high half.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_sdckb_i, pad_sdcka_i};
        synced = sync_q[SYNC_STAGES-1];
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < NL; i++) begin
            if (synced[i] != filt_q[i]) begin
                if (fcnt_q[i] == FCW'(FILTER_LEN - 1)) begin
                    filt_d[i] = synced[i];
                    fcnt_d[i] = '0;
                end else begin
                    fcnt_d[i] = fcnt_q[i] + FCW'(1);
                end
            end else begin
                fcnt_d[i] = '0;
            end
        end
        filt_a_d = filt_d[NUM_PORTS-1:0];
        filt_b_d = filt_d[NL-1:NUM_PORTS];
    end

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        turn_d  = turn_q;
        timer_d = timer_q;
        seen_d  = seen_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        tx_rise = core.tx_active & ~tx_prev_q;
        tx_fall = ~core.tx_active & tx_prev_q;
        rx_fall = ~core.rx_active & rx_prev_q;
        sel_ok  = {{(32-PSEL_W){1'b0}}, cfg_port_sel} < 32'(NUM_PORTS);
        coll_d  = tx_rise & ~grant_q;

        case (state_q)
            ST_IDLE: begin
                if (tx_rise) begin
                    state_d = ST_DRIVE;
                    port_d  = sel_ok ? cfg_port_sel : '0;
                end
            end
            ST_DRIVE: begin
                if (tx_fall) begin
                    state_d = ST_TURN;
                    turn_d  = TCW'(TURN_CYCLES - 1);
                end
            end
            ST_TURN: begin
                if (turn_q == '0) begin
                    if (cfg_enable_rx && !cfg_loopback) begin
                        state_d = ST_LISTEN;
                        timer_d = '0;
                        seen_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    turn_d = turn_q - TCW'(1);
                end
            end
            ST_LISTEN: begin
                timer_d = timer_q + TIMEOUT_W'(1);
                seen_d  = seen_q | core.rx_active;
                // A receiver becoming active in the expiry cycle takes priority over the timeout.
                if (seen_q && rx_fall) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (!seen_q && !core.rx_active && (cfg_rx_timeout != '0) &&
                             (timer_q == cfg_rx_timeout - TIMEOUT_W'(1))) begin
                    state_d = ST_IDLE;
                    tmo_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they change on the same edge as the state.
    always_comb begin
        oe_d    = '0;
        pad_a_d = '1;
        pad_b_d = '1;
        rx_a_d  = 1'b1;
        rx_b_d  = 1'b1;
        grant_d = (state_d == ST_IDLE);
        if (state_d == ST_DRIVE) begin
            if (cfg_loopback) begin
                rx_a_d = core.tx_sdcka;
                rx_b_d = core.tx_sdckb;
            end else if (cfg_enable_tx) begin
                oe_d[port_d]    = 1'b1;
                pad_a_d[port_d] = core.tx_sdcka;
                pad_b_d[port_d] = core.tx_sdckb;
            end
        end else if (state_d == ST_LISTEN) begin
            rx_a_d = filt_a_d[port_d];
            rx_b_d = filt_b_d[port_d];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            port_q    <= '0;
            turn_q    <= '0;
            timer_q   <= '0;
            seen_q    <= 1'b0;
            tx_prev_q <= 1'b0;
            rx_prev_q <= 1'b0;
            sync_q    <= '1;
            filt_q    <= '1;
            fcnt_q    <= '0;
            oe_q      <= '0;
            pad_a_q   <= '1;
            pad_b_q   <= '1;
            rx_a_q    <= 1'b1;
            rx_b_q    <= 1'b1;
            grant_q   <= 1'b1;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            coll_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            turn_q    <= turn_d;
            timer_q   <= timer_d;
            seen_q    <= seen_d;
            tx_prev_q <= core.tx_active;
            rx_prev_q <= core.rx_active;
            sync_q    <= sync_d;
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            oe_q      <= oe_d;
            pad_a_q   <= pad_a_d;
            pad_b_q   <= pad_b_d;
            rx_a_q    <= rx_a_d;
            rx_b_q    <= rx_b_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            coll_q    <= coll_d;
        end
    end

    assign state         = state_q;
    assign pad_oe        = oe_q;
    assign pad_sdcka_o   = pad_a_q;
    assign pad_sdckb_o   = pad_b_q;
    assign core.tx_grant = grant_q;
    assign core.rx_sdcka = rx_a_q;
    assign core.rx_sdckb = rx_b_q;
    assign rx_done       = done_q;
    assign rx_timeout    = tmo_q;
    assign tx_collision  = coll_q;
endmodule

// File: tb/tb_maple_phy_ctrl.sv
// tb/tb_maple_phy_ctrl.sv - Self-checking bench for maple_phy_ctrl
module tb_maple_phy_ctrl;
    localparam int NP = 4;
    localparam int SS = 2;
    localparam int FL = 3;
    localparam int TC = 8;
    localparam int TW = 20;
    localparam int RN = 300;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [1:0]    cfg_port_sel = '0;
    logic          cfg_enable_tx = 1'b0;
    logic          cfg_enable_rx = 1'b0;
    logic          cfg_loopback = 1'b0;
    logic [TW-1:0] cfg_rx_timeout = '0;
    logic [NP-1:0] pad_sdcka_i = '1;
    logic [NP-1:0] pad_sdckb_i = '1;
    logic [NP-1:0] pad_sdcka_o, pad_sdckb_o, pad_oe;
    logic [1:0]    state;
    logic          rx_done, rx_timeout, tx_collision;

    maple_core_if core_if ();

    maple_phy_ctrl #(
        .NUM_PORTS(NP), .SYNC_STAGES(SS), .FILTER_LEN(FL), .TURN_CYCLES(TC), .TIMEOUT_W(TW)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_port_sel(cfg_port_sel), .cfg_enable_tx(cfg_enable_tx), .cfg_enable_rx(cfg_enable_rx),
        .cfg_loopback(cfg_loopback), .cfg_rx_timeout(cfg_rx_timeout),
        .core(core_if),
        .pad_sdcka_i(pad_sdcka_i), .pad_sdckb_i(pad_sdckb_i),
        .pad_sdcka_o(pad_sdcka_o), .pad_sdckb_o(pad_sdckb_o), .pad_oe(pad_oe),
        .state(state), .rx_done(rx_done), .rx_timeout(rx_timeout), .tx_collision(tx_collision)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [1:0]    sel;
        logic          en_tx;
        logic          en_rx;
        logic          lb;
        logic [NP-1:0] exp_oe;
        logic [1:0]    exp_after;
    } vec_t;

    vec_t vecs [6];
    int   errs = 0;
    int   checks = 0;
    logic ha [RN];
    logic hb [RN];

    localparam logic [31:0] RESET_OUTS = 32'({2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'hF, 4'hF});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge aclk);
    endtask

    function automatic logic [31:0] outs();
        return 32'({state, core_if.tx_grant, core_if.rx_sdcka, core_if.rx_sdckb, rx_done, rx_timeout,
                    tx_collision, pad_oe, pad_sdcka_o, pad_sdckb_o});
    endfunction

    // Pad history reference: values before the random run are idle-high.
    function automatic logic hist(input logic line_b, input int idx);
        if (idx < 0) return 1'b1;
        return line_b ? hb[idx] : ha[idx];
    endfunction

    // The filtered line flips once the last FL synchronised samples all disagree with it.
    function automatic logic flips(input logic line_b, input int n, input logic cur);
        for (int j = 0; j < FL; j++)
            if (hist(line_b, n - SS - j) == cur) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_state(input logic [1:0] tgt, input int budget, input string name);
        int n = 0;
        while (state !== tgt && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(state), 32'(tgt));
    endtask

    task automatic run_to_listen(input logic [1:0] sel);
        cfg_port_sel  = sel;
        cfg_enable_tx = 1'b1;
        cfg_enable_rx = 1'b1;
        cfg_loopback  = 1'b0;
        core_if.tx_active = 1'b1;
        repeat (3) begin
            core_if.tx_sdcka = 1'($urandom);
            core_if.tx_sdckb = 1'($urandom);
            step();
        end
        core_if.tx_active = 1'b0;
        step();
        wait_state(2'd3, 4 * TC, "listen_entry");
    endtask

    task automatic run_vec(input vec_t v);
        logic a, b, saw;
        int   n;
        cfg_port_sel   = v.sel;
        cfg_enable_tx  = v.en_tx;
        cfg_enable_rx  = v.en_rx;
        cfg_loopback   = v.lb;
        cfg_rx_timeout = 5;
        for (int c = 0; c < 7; c++) begin
            a = 1'($urandom);
            b = 1'($urandom);
            core_if.tx_sdcka  = a;
            core_if.tx_sdckb  = b;
            core_if.tx_active = 1'b1;
            if (c == 2) cfg_port_sel = v.sel + 2'd1;
            step();
            chk("drive", 32'({state, core_if.tx_grant, pad_oe, pad_sdcka_o, pad_sdckb_o,
                              core_if.rx_sdcka, core_if.rx_sdckb}),
                32'({2'd1, 1'b0, v.exp_oe, ~v.exp_oe | {NP{a}}, ~v.exp_oe | {NP{b}},
                     v.lb ? a : 1'b1, v.lb ? b : 1'b1}));
        end
        core_if.tx_active = 1'b0;
        step();
        chk("turn_entry", 32'({state, pad_oe, core_if.rx_sdcka, core_if.rx_sdckb}), 32'({2'd2, 4'h0, 2'b11}));
        n = 0;
        while (state === 2'd2 && n < 4 * TC) begin
            n++;
            step();
        end
        chk("turn_len", 32'(n), 32'(TC));
        chk("after_turn", 32'(state), 32'(v.exp_after));
        if (v.exp_after == 2'd3) begin
            saw = 1'b0;
            for (int k = 0; k < 10 && state !== 2'd0; k++) begin
                step();
                if (rx_timeout) saw = 1'b1;
            end
            chk("row_timeout", 32'(saw), 32'(1));
        end
        cfg_port_sel = v.sel;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       saw, cur_a, cur_b, ref_a, ref_b;
        logic [1:0] p;
        logic [NP-1:0] na, nb;
        int         ndone, first_to, run_a, run_b;

        vecs[0] = '{2'd2, 1'b1, 1'b0, 1'b0, 4'b0100, 2'd0};
        vecs[1] = '{2'd0, 1'b1, 1'b0, 1'b0, 4'b0001, 2'd0};
        vecs[2] = '{2'd3, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd0};
        vecs[3] = '{2'd1, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd0};
        vecs[4] = '{2'd1, 1'b1, 1'b1, 1'b1, 4'b0000, 2'd0};
        vecs[5] = '{2'd3, 1'b1, 1'b1, 1'b0, 4'b1000, 2'd3};

        core_if.tx_sdcka  = 1'b1;
        core_if.tx_sdckb  = 1'b1;
        core_if.tx_active = 1'b0;
        core_if.rx_active = 1'b0;

        repeat (3) step();
        chk("reset_held", outs(), RESET_OUTS);
        aresetn = 1'b1;
        step();
        chk("reset_released", outs(), RESET_OUTS);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Receive on port 2: glitch rejection, 5-cycle latency, single rx_done
        cfg_rx_timeout = 100;
        run_to_listen(2'd2);
        pad_sdcka_i[2] = 1'b0;
        step();
        step();
        pad_sdcka_i[2] = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            step();
            if (core_if.rx_sdcka !== 1'b1) saw = 1'b1;
        end
        chk("glitch_hidden", 32'(saw), 32'(0));
        pad_sdcka_i[2] = 1'b0;
        pad_sdckb_i[2] = 1'b0;
        pad_sdcka_i[1] = 1'b0;
        repeat (4) step();
        chk("latency_4", 32'({core_if.rx_sdcka, core_if.rx_sdckb}), 32'(2'b11));
        step();
        chk("latency_5", 32'({core_if.rx_sdcka, core_if.rx_sdckb}), 32'(2'b00));
        core_if.rx_active = 1'b1;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (rx_done) ndone++;
        end
        core_if.rx_active = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (rx_done) ndone++;
        end
        chk("rx_done_once", 32'(ndone), 32'(1));
        chk("rx_idle", 32'({state, core_if.rx_sdcka, core_if.rx_sdckb}), 32'({2'd0, 2'b11}));
        pad_sdcka_i = '1;
        pad_sdckb_i = '1;

        // Timeout after 100 cycles, with a collision raised mid-window
        run_to_listen(2'd2);
        first_to = 0;
        for (int k = 1; k <= 100; k++) begin
            if (k == 50) core_if.tx_active = 1'b1;
            if (k == 53) core_if.tx_active = 1'b0;
            step();
            if (k == 50)
                chk("collision", 32'({tx_collision, pad_oe, state}), 32'({1'b1, 4'h0, 2'd3}));
            if (k == 51) chk("collision_pulse", 32'(tx_collision), 32'(0));
            if (rx_timeout && first_to == 0) first_to = k;
        end
        chk("timeout_cycle", 32'(first_to), 32'(100));
        chk("timeout_idle", 32'(state), 32'(0));
        step();
        chk("timeout_pulse", 32'(rx_timeout), 32'(0));

        // rx_active in the expiry cycle wins over the timeout
        run_to_listen(2'd2);
        repeat (99) step();
        core_if.rx_active = 1'b1;
        step();
        chk("expiry_rx_wins", 32'({state, rx_timeout}), 32'({2'd3, 1'b0}));
        repeat (3) step();
        core_if.rx_active = 1'b0;
        step();
        chk("expiry_rx_done", 32'({rx_done, state}), 32'({1'b1, 2'd0}));

        // Random pad activity on a random port against the filter reference
        cfg_rx_timeout = '0;
        p = 2'($urandom_range(0, NP - 1));
        run_to_listen(p);
        cur_a = 1'b1; cur_b = 1'b1; ref_a = 1'b1; ref_b = 1'b1; run_a = 0; run_b = 0;
        for (int n = 0; n < RN; n++) begin
            if (run_a == 0) begin cur_a = ~cur_a; run_a = $urandom_range(1, 5); end
            if (run_b == 0) begin cur_b = ~cur_b; run_b = $urandom_range(1, 5); end
            run_a--;
            run_b--;
            na = NP'($urandom);
            nb = NP'($urandom);
            na[p] = cur_a;
            nb[p] = cur_b;
            pad_sdcka_i = na;
            pad_sdckb_i = nb;
            ha[n] = cur_a;
            hb[n] = cur_b;
            step();
            if (flips(1'b0, n, ref_a)) ref_a = ~ref_a;
            if (flips(1'b1, n, ref_b)) ref_b = ~ref_b;
            chk("rand_rx", 32'({state, core_if.rx_sdcka, core_if.rx_sdckb}), 32'({2'd3, ref_a, ref_b}));
        end
        pad_sdcka_i = '1;
        pad_sdckb_i = '1;
        core_if.rx_active = 1'b1;
        step();
        core_if.rx_active = 1'b0;
        wait_state(2'd0, 5, "rand_exit");
        repeat (8) step();

        // Reset during DRIVE drops pad_oe without a clock edge
        cfg_port_sel  = 2'd1;
        cfg_enable_tx = 1'b1;
        cfg_loopback  = 1'b0;
        core_if.tx_active = 1'b1;
        step();
        chk("pre_reset_oe", 32'(pad_oe), 32'(4'b0010));
        #2;
        aresetn = 1'b0;
        #1;
        chk("async_reset", outs(), RESET_OUTS);
        core_if.tx_active = 1'b0;
        step();
        step();
        aresetn = 1'b1;
        step();
        chk("post_reset", outs(), RESET_OUTS);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
